// File: rtl/nic_pkg.sv
// nic_pkg: flit field layout, flit types, VC states and helpers.
// Shared by the input port, its VC buffers and the bench.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 4
`endif

package nic_pkg;

    localparam int DEF_FLIT_WIDTH        = `FLIT_WIDTH;
    localparam int DEF_MAX_PACKET_LENGTH = `MAX_PACKET_LENGHT;

    // Field positions inside a flit.
    // vnet/vc are wider than needed so bad indices can be detected.
    localparam int TYPE_LSB = 0;
    localparam int TYPE_W   = 2;
    localparam int VNET_LSB = 2;
    localparam int VNET_W   = 2;
    localparam int VC_LSB   = 4;
    localparam int VC_W     = 2;

    typedef enum logic [1:0] {
        HEAD      = 2'd0,
        BODY      = 2'd1,
        TAIL      = 2'd2,
        HEAD_TAIL = 2'd3
    } flit_type_t;

    typedef enum logic [1:0] {
        VC_IDLE,
        VC_COLLECT,
        VC_READY
    } vc_state_t;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic int vc_index(
        input int vnet,
        input int vc,
        input int n_vc_per_vnet
    );
        return vnet * n_vc_per_vnet + vc;
    endfunction

endpackage

// File: rtl/input_port_vc_rr_if.sv
// input_port_vc_rr_if: packet hand-off to the pkt-to-msg stage.
// master drives packet + r_pkt_to_msg; slave drives stall_pkt_to_msg.
interface input_port_vc_rr_if #(
    parameter int FLIT_WIDTH        = 32,
    parameter int MAX_PACKET_LENGTH = 4,
    parameter int N_BITS_VC         = 3,
    parameter int LEN_W             = 3
);
    logic                                      r_pkt_to_msg;
    logic [MAX_PACKET_LENGTH*FLIT_WIDTH-1:0]   out_link;
    logic [LEN_W-1:0]                          out_len;
    logic [N_BITS_VC-1:0]                      out_vc;
    logic                                      stall_pkt_to_msg;

    modport master (
        output r_pkt_to_msg,
        output out_link,
        output out_len,
        output out_vc,
        input  stall_pkt_to_msg
    );

    modport slave (
        input  r_pkt_to_msg,
        input  out_link,
        input  out_len,
        input  out_vc,
        output stall_pkt_to_msg
    );
endinterface

// File: rtl/vc_packet_buffer.sv
// vc_packet_buffer: one VC's packet FSM, flit slots, length and credit drain.
// Ports: clk, rst (async low); wr_en_i/flit_i flit write; xfer_i packet taken;
//   ready_o/link_o/len_o packet view; credit_o/free_o returns;
//   illegal_o (only with INPUT_PORT_PROTOCOL_CHECK_EN) flags a dropped flit.
module vc_packet_buffer
    import nic_pkg::*;
#(
    parameter int FLIT_WIDTH        = 32,
    parameter int MAX_PACKET_LENGTH = 4,
    parameter int LEN_W             = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
`ifdef INPUT_PORT_PROTOCOL_CHECK_EN
    output logic                                    illegal_o,
`endif
    input  logic                                    wr_en_i,
    input  logic [FLIT_WIDTH-1:0]                   flit_i,
    input  logic                                    xfer_i,
    output logic                                    ready_o,
    output logic [MAX_PACKET_LENGTH*FLIT_WIDTH-1:0] link_o,
    output logic [LEN_W-1:0]                        len_o,
    output logic                                    credit_o,
    output logic                                    free_o
);

    vc_state_t             state;
    logic [FLIT_WIDTH-1:0] slot [MAX_PACKET_LENGTH];
    logic [LEN_W-1:0]      len;
    logic [LEN_W-1:0]      cnt;
    flit_type_t            ftype;
    logic                  room;
    logic                  accept;
    logic                  take;

    assign ftype = flit_type_t'(flit_i[TYPE_LSB +: TYPE_W]);
    assign room  = int'(len) < MAX_PACKET_LENGTH;

    // A new packet may only start once the previous one's credits are home.
    always_comb begin
        accept = 1'b0;
        unique case (state)
            VC_IDLE:
                accept = (ftype == HEAD || ftype == HEAD_TAIL)
                      && (cnt == '0);
            VC_COLLECT:
                accept = (ftype == BODY || ftype == TAIL) && room;
            default:
                accept = 1'b0;
        endcase
    end

    assign take = wr_en_i && accept;

`ifdef INPUT_PORT_PROTOCOL_CHECK_EN
    assign illegal_o = wr_en_i && !accept;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= VC_IDLE;
            len   <= '0;
            cnt   <= '0;
            for (int i = 0; i < MAX_PACKET_LENGTH; i++) slot[i] <= '0;
        end else begin
            if (cnt != '0) cnt <= cnt - LEN_W'(1);
            unique case (state)
                VC_IDLE: begin
                    if (take) begin
                        slot[0] <= flit_i;
                        len     <= LEN_W'(1);
                        state   <= (ftype == HEAD_TAIL) ? VC_READY
                                                        : VC_COLLECT;
                    end
                end
                VC_COLLECT: begin
                    if (take) begin
                        for (int i = 0; i < MAX_PACKET_LENGTH; i++)
                            if (i == int'(len)) slot[i] <= flit_i;
                        len <= len + LEN_W'(1);
                        if (ftype == TAIL) state <= VC_READY;
                    end
                end
                VC_READY: begin
                    if (xfer_i) begin
                        for (int i = 0; i < MAX_PACKET_LENGTH; i++)
                            slot[i] <= '0;
                        len   <= '0;
                        cnt   <= len;
                        state <= VC_IDLE;
                    end
                end
                default: state <= VC_IDLE;
            endcase
        end
    end

    always_comb begin
        link_o = '0;
        for (int i = 0; i < MAX_PACKET_LENGTH; i++)
            link_o[i*FLIT_WIDTH +: FLIT_WIDTH] = slot[i];
    end

    assign ready_o  = (state == VC_READY);
    assign len_o    = len;
    assign credit_o = (cnt != '0);
    assign free_o   = (cnt == LEN_W'(1));

endmodule

// File: rtl/input_port_vc_rr.sv
// input_port_vc_rr: demuxes router flits into per-VC packet buffers and hands
// whole packets to pkt-to-msg one at a time through a locking round-robin.
// Ports: clk, rst (async low); in_link_i/is_valid_i flit in;
//   credit_signal_o/free_signal_o per-VC; pkt_if (master) packet out; err_o.
// Macro INPUT_PORT_PROTOCOL_CHECK_EN: err_o latches any dropped flit.
module input_port_vc_rr
    import nic_pkg::*;
#(
    parameter int N_VNET            = 3,
    parameter int N_VC_PER_VNET     = 2,
    parameter int FLIT_WIDTH        = DEF_FLIT_WIDTH,
    parameter int MAX_PACKET_LENGTH = DEF_MAX_PACKET_LENGTH,
    parameter int N_TOT_OF_VC       = N_VNET * N_VC_PER_VNET,
    parameter int N_BITS_VC         = clog2(N_TOT_OF_VC),
    parameter int LEN_W             = clog2(MAX_PACKET_LENGTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  in_link_i,
    input  logic                   is_valid_i,
    output logic [N_TOT_OF_VC-1:0] credit_signal_o,
    output logic [N_TOT_OF_VC-1:0] free_signal_o,
    input_port_vc_rr_if.master     pkt_if,
    output logic                   err_o
);

    localparam int PW = MAX_PACKET_LENGTH * FLIT_WIDTH;

    logic [VNET_W-1:0]      f_vnet;
    logic [VC_W-1:0]        f_vc;
    logic                   in_range;
    int                     tgt;
    logic [N_TOT_OF_VC-1:0] wr_en;
    logic [N_TOT_OF_VC-1:0] xfer;
    logic [N_TOT_OF_VC-1:0] ready;
    logic [PW-1:0]          link [N_TOT_OF_VC];
    logic [LEN_W-1:0]       len  [N_TOT_OF_VC];
    logic [N_BITS_VC-1:0]   ptr;
    logic [N_BITS_VC-1:0]   grant;
    logic [N_BITS_VC-1:0]   pick;
    logic [N_BITS_VC-1:0]   sel;
    logic                   lock;
    logic                   found;
    logic                   r_pkt;
    logic                   do_xfer;

    assign f_vnet   = in_link_i[VNET_LSB +: VNET_W];
    assign f_vc     = in_link_i[VC_LSB +: VC_W];
    assign in_range = (int'(f_vnet) < N_VNET)
                   && (int'(f_vc) < N_VC_PER_VNET);
    assign tgt      = vc_index(int'(f_vnet), int'(f_vc), N_VC_PER_VNET);

`ifdef INPUT_PORT_PROTOCOL_CHECK_EN
    logic [N_TOT_OF_VC-1:0] ill;
`endif

    for (genvar v = 0; v < N_TOT_OF_VC; v++) begin : g_vc
        assign wr_en[v] = is_valid_i && in_range && (tgt == v);
        assign xfer[v]  = do_xfer && (sel == N_BITS_VC'(v));

        vc_packet_buffer #(
            .FLIT_WIDTH        (FLIT_WIDTH),
            .MAX_PACKET_LENGTH (MAX_PACKET_LENGTH),
            .LEN_W             (LEN_W)
        ) u_buf (
            .clk       (clk),
            .rst       (rst),
`ifdef INPUT_PORT_PROTOCOL_CHECK_EN
            .illegal_o (ill[v]),
`endif
            .wr_en_i   (wr_en[v]),
            .flit_i    (in_link_i),
            .xfer_i    (xfer[v]),
            .ready_o   (ready[v]),
            .link_o    (link[v]),
            .len_o     (len[v]),
            .credit_o  (credit_signal_o[v]),
            .free_o    (free_signal_o[v])
        );
    end

    // First READY VC at or above ptr, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = ptr;
        idx   = 0;
        for (int i = 0; i < N_TOT_OF_VC; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_TOT_OF_VC) idx = idx - N_TOT_OF_VC;
            if (!found && ready[idx]) begin
                found = 1'b1;
                pick  = N_BITS_VC'(idx);
            end
        end
    end

    // A stalled offer is frozen until it is taken.
    assign sel     = lock ? grant : pick;
    assign r_pkt   = ready[sel];
    assign do_xfer = r_pkt && !pkt_if.stall_pkt_to_msg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            grant <= '0;
            lock  <= 1'b0;
        end else if (do_xfer) begin
            ptr  <= (sel == N_BITS_VC'(N_TOT_OF_VC - 1)) ? '0
                  : sel + N_BITS_VC'(1);
            lock <= 1'b0;
        end else if (r_pkt) begin
            lock  <= 1'b1;
            grant <= sel;
        end
    end

    assign pkt_if.r_pkt_to_msg = r_pkt;
    assign pkt_if.out_link     = r_pkt ? link[sel] : '0;
    assign pkt_if.out_len      = r_pkt ? len[sel]  : '0;
    assign pkt_if.out_vc       = r_pkt ? sel       : '0;

`ifdef INPUT_PORT_PROTOCOL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= 1'b0;
        else if (is_valid_i && (!in_range || (|ill)))
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
